tanh_act_block: RTL and testbench
=================================

// Module: tanh_act_block
// PURPOSE
//  Parametrised successor of the serial tanh forward stage. It activates a DIM-element hidden vector
//  through LANES parallel tanh_table instances, processing one group of LANES elements per cycle.
//  Two modes: FWD outputs y=tanh(x); DERIV outputs 1-y^2, the local gradient used by the backward pass.
//  Sits between the hidden-layer matmul and the next layer or backward block, under run/valid control.
// PARAMETERS
//  DIM      24        vector length; must be a multiple of LANES
//  LANES    4         parallel table lookups per cycle; NG = DIM/LANES groups
//  IN_W     `N_LEN    input element width (signed); must equal the tanh_table input width
//  OUT_W    `N_LEN_W  output element width (signed); must equal the tanh_table output width
//  FRAC_W   OUT_W-2   output fraction bits; ONE = 1<<FRAC_W
//  TBL_LAT  2         tanh_table latency in clocks, from d to q
// PORTS
//  clk    in   1          rising-edge clock
//  rst_n  in   1          asynchronous active-low reset
//  run    in   1          level: hold high to compute; low = idle/abort
//  mode   in   1          0=FWD tanh(x), 1=DERIV 1-tanh(x)^2; sampled on first run cycle
//  d      in   DIM*IN_W   element i at d[i*IN_W +: IN_W]; must be stable while run=1
//  valid  out  1          run & all NG groups written for this run
//  done   out  1          one-cycle pulse in the first cycle valid is high
//  q      out  DIM*OUT_W  element i at q[i*OUT_W +: OUT_W]; registered, holds between runs
// BEHAVIOUR
//  Reset: q=0 (all elements), valid=0, done=0, group counter=0, all pipeline tags cleared.
//  Group counter g: 0 while run=0. Counts 0..NG-1 while run=1, then saturates at NG-1.
//  Issue: lanes read d[(g*LANES+l)] for l=0..LANES-1. A tag {gidx, live} enters the delay line only
//   for cycles with run=1 and g not yet saturated. Each group is issued exactly once per run.
//  mode_r: latched on the cycle where run=1 and no prior run cycle exists (run rising); held until
//   run falls. A mode change mid-run is ignored.
//  Pipeline, for group issued in cycle c: table q valid in cycle c+TBL_LAT; post stage registered at
//   the end of that cycle; q_buf group written at the end of cycle c+TBL_LAT+1 and visible in cycle
//   c+TBL_LAT+2. The post stage is present in both modes, so latency does not depend on mode.
//  Post stage, FWD: y passed through unchanged.
//  Post stage, DERIV: s = (y*y) >>> FRAC_W (full 2*OUT_W product, truncate); r = ONE - s.
//   Clamp r to [0, ONE]. Output width OUT_W.
//  valid: run & last_written, where last_written sets when group NG-1 is written this run.
//   First high in cycle NG+TBL_LAT+1, counting run's first high cycle as cycle 0.
//   Defaults: cycle 9. With LANES=1, DIM=24: cycle 27.
//  done: valid & ~valid_d (registered previous valid). Exactly one pulse per completed run.
//  Abort (run falls before valid): counter->0, live tags cleared at the next edge, last_written
//   cleared. In-flight groups are NOT written. Already-written groups keep their new values, so q
//   may mix old and new data; consumers rely only on valid. valid/done drop in the same cycle.
//  run low for >=1 cycle then high: a fresh run restarts from group 0. q holds old values until
//   each group is overwritten.
//  run held high after valid: no further writes; q and valid stable; done does not repeat.
//  Reset asserted mid-run: immediate clear to reset state; no write completes.
//  Out-of-range inputs: saturation is handled by tanh_table. This block adds no further saturation
//   in FWD mode.
// TESTING
//  1 Reset: rst_n=0 with run=1 -> q=0, valid=0, done=0; release rst_n with run=0 -> outputs unchanged.
//  2 FWD, defaults, d[i]=i*512: run high at cycle 0 -> valid/done rise at cycle 9, done pulses 1 cycle,
//    q[i]=golden tanh_table(d[i]) for all 24 elements.
//  3 DERIV, d all 0: -> q[i]=ONE (16384 at OUT_W=16).
//    d at table max -> q[i]=ONE-((ymax^2)>>>FRAC_W), never negative.
//  4 Abort: run high cycles 0..4 then low, previous q=all 0x7 -> valid never rises;
//    groups 0..2 updated, groups 3..5 still 0x7.
//  5 Mode toggled mid-run and back-to-back runs with a 1-cycle gap and new d -> output follows
//    latched mode; second done at cycle 9 of run 2.
//  6 Sweep LANES in {1,2,3,6,24} and TBL_LAT in {1,3} -> first valid at NG+TBL_LAT+1,
//    q matches the golden model.

Source files
------------

// File: rtl/tanh_act_if.sv
// rtl/tanh_act_if.sv - run/valid bundle between a hidden-vector producer and tanh_act_block
// Purpose : groups the control, operand and result signals of the tanh activation stage.
// Signals : run, mode, d[DIM*IN_W]    driven by the master (producer side)
//           valid, done, q[DIM*OUT_W] driven by the slave (tanh_act_block)
interface tanh_act_if #(
    parameter int DIM   = 24,
    parameter int IN_W  = 16,
    parameter int OUT_W = 16
);
    logic                 run;
    logic                 mode;
    logic [DIM*IN_W-1:0]  d;
    logic                 valid;
    logic                 done;
    logic [DIM*OUT_W-1:0] q;

    modport master (output run, mode, d, input valid, done, q);
    modport slave  (input run, mode, d, output valid, done, q);
endinterface

// File: rtl/tanh_act_block.sv
// rtl/tanh_act_block.sv - LANES-parallel tanh / tanh-derivative activation of a DIM-element vector
// Purpose : tanh_table is a piecewise-linear tanh lookup (input Q4.(IN_W-4), output Q2.(OUT_W-2))
//           with LAT register stages. tanh_act_block issues one group of LANES elements per run
//           cycle into LANES tables, optionally maps y -> 1-y^2, and writes each group into q.
// Ports   : clk, rst_n (async, active low)
//           bus.run/mode/d in; bus.valid/done/q out (see tanh_act_if)
module tanh_table #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  d,
    output logic [OUT_W-1:0] q
);
    localparam int IN_FRAC = IN_W - 4;
    localparam int SH      = (OUT_W - 2) - IN_FRAC;
    localparam int AW      = (IN_W + 4 > OUT_W + 1) ? IN_W + 4 : OUT_W + 1;
    localparam logic [AW-1:0] HALF  = AW'(1) << (IN_FRAC - 1);
    localparam logic [AW-1:0] ONE_I = AW'(1) << IN_FRAC;
    localparam logic [AW-1:0] TWO   = AW'(2) << IN_FRAC;
    localparam logic [AW-1:0] THREE = AW'(3) << IN_FRAC;
    localparam logic [AW-1:0] K5    = AW'(5);
    // Value of the curve at |x| = 2, start of the last (slope 1/32) segment.
    localparam logic [AW-1:0] MID   = HALF + (((TWO - HALF) * K5) >> 4);

    logic [IN_W:0]    dx;
    logic [IN_W:0]    ax;
    logic [AW-1:0]    a;
    logic [AW-1:0]    m;
    logic [OUT_W-1:0] ym;
    logic [OUT_W-1:0] y_comb;
    logic [OUT_W-1:0] pipe [LAT];

    // Odd-symmetric curve: slope 1 up to 0.5, 5/16 up to 2, 1/32 up to 3, then exactly 1.0.
    always_comb begin
        dx = {d[IN_W-1], d};
        ax = dx[IN_W] ? (~dx + (IN_W+1)'(1)) : dx;
        a  = {{(AW-IN_W-1){1'b0}}, ax};
        if (a < HALF)       m = a;
        else if (a < TWO)   m = HALF + (((a - HALF) * K5) >> 4);
        else if (a < THREE) m = MID + ((a - TWO) >> 5);
        else                m = ONE_I;
        ym     = OUT_W'(m << SH);
        y_comb = d[IN_W-1] ? (~ym + OUT_W'(1)) : ym;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= y_comb;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[LAT-1];
endmodule

module tanh_act_block #(
    parameter int DIM     = 24,
    parameter int LANES   = 4,
    parameter int IN_W    = 16,
    parameter int OUT_W   = 16,
    parameter int FRAC_W  = OUT_W - 2,
    parameter int TBL_LAT = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    tanh_act_if.slave bus
);
    localparam int NG    = DIM / LANES;
    localparam int GW    = (NG > 1) ? $clog2(NG) : 1;
    localparam int GRP_W = LANES * OUT_W;
    localparam int PW    = 2 * OUT_W;
    localparam logic signed [PW-1:0] ONE_P  = PW'(1) << FRAC_W;
    localparam logic [GW-1:0]        LAST_G = GW'(NG - 1);

    logic [GW-1:0]        g;
    logic                 sat;
    logic                 run_d;
    logic                 mode_r;
    logic                 issue;
    logic                 tag_live [TBL_LAT];
    logic [GW-1:0]        tag_gidx [TBL_LAT];
    logic                 post_live;
    logic [GW-1:0]        post_gidx;
    logic [GRP_W-1:0]     post_q;
    logic [GRP_W-1:0]     post_next;
    logic                 last_written;
    logic                 valid_d;
    logic [DIM*OUT_W-1:0] q_buf;
    logic [IN_W-1:0]      lane_d [LANES];
    logic [OUT_W-1:0]     lane_y [LANES];
    logic signed [PW-1:0] ys;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] r;

    // sat marks that the last group has been issued, so each group enters the pipe once per run.
    assign issue = bus.run & ~sat;

    always_comb begin
        for (int l = 0; l < LANES; l++)
            lane_d[l] = bus.d[(int'(g) * LANES + l) * IN_W +: IN_W];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        tanh_table #(.IN_W(IN_W), .OUT_W(OUT_W), .LAT(TBL_LAT)) u_tbl (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (lane_d[l]),
            .q     (lane_y[l])
        );
    end

    // Post stage: pass-through in FWD, 1 - y^2 clamped to [0, ONE] in DERIV.
    always_comb begin
        post_next = '0;
        ys        = '0;
        prod      = '0;
        r         = '0;
        for (int l = 0; l < LANES; l++) begin
            ys   = PW'($signed(lane_y[l]));
            prod = ys * ys;
            r    = ONE_P - (prod >>> FRAC_W);
            if (r < 0)          r = '0;
            else if (r > ONE_P) r = ONE_P;
            post_next[l*OUT_W +: OUT_W] = mode_r ? OUT_W'(r) : lane_y[l];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g            <= '0;
            sat          <= 1'b0;
            run_d        <= 1'b0;
            mode_r       <= 1'b0;
            post_live    <= 1'b0;
            post_gidx    <= '0;
            post_q       <= '0;
            last_written <= 1'b0;
            valid_d      <= 1'b0;
            q_buf        <= '0;
            for (int i = 0; i < TBL_LAT; i++) begin
                tag_live[i] <= 1'b0;
                tag_gidx[i] <= '0;
            end
        end else begin
            run_d   <= bus.run;
            valid_d <= bus.valid;
            if (bus.run && !run_d) mode_r <= bus.mode;

            if (!bus.run) begin
                g   <= '0;
                sat <= 1'b0;
            end else if (!sat) begin
                if (g == LAST_G) sat <= 1'b1;
                else             g   <= g + GW'(1);
            end

            // Tags move alongside the table pipeline; run low kills every live tag at this edge.
            tag_live[0] <= issue;
            tag_gidx[0] <= g;
            for (int i = 1; i < TBL_LAT; i++) begin
                tag_live[i] <= bus.run & tag_live[i-1];
                tag_gidx[i] <= tag_gidx[i-1];
            end
            post_live <= bus.run & tag_live[TBL_LAT-1];
            post_gidx <= tag_gidx[TBL_LAT-1];
            post_q    <= post_next;

            if (post_live) begin
                for (int gi = 0; gi < NG; gi++)
                    if (post_gidx == GW'(gi)) q_buf[gi*GRP_W +: GRP_W] <= post_q;
            end

            if (!bus.run)                               last_written <= 1'b0;
            else if (post_live && post_gidx == LAST_G) last_written <= 1'b1;
        end
    end

    assign bus.valid = bus.run & last_written;
    assign bus.done  = bus.valid & ~valid_d;
    assign bus.q     = q_buf;
endmodule

// File: tb/tb_tanh_act_block.sv
// tb/tb_tanh_act_block.sv - bench for tanh_act_block across six LANES/TBL_LAT configurations
module tb_tanh_act_block;
    localparam int DIM   = 24;
    localparam int IN_W  = 16;
    localparam int OUT_W = 16;
    localparam int NCFG  = 6;

    function automatic int cfg_lanes(int k);
        case (k)
            0: return 4;
            1: return 1;
            2: return 2;
            3: return 3;
            4: return 6;
            default: return 24;
        endcase
    endfunction

    function automatic int cfg_lat(int k);
        case (k)
            0: return 2;
            1: return 1;
            2: return 3;
            3: return 1;
            4: return 3;
            default: return 1;
        endcase
    endfunction

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 run;
    logic                 mode;
    logic [DIM*IN_W-1:0]  d;
    logic                 valid_a [NCFG];
    logic                 done_a  [NCFG];
    logic [DIM*OUT_W-1:0] q_a     [NCFG];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NCFG; k++) begin : g_cfg
        tanh_act_if #(.DIM(DIM), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();
        assign bus.run   = run;
        assign bus.mode  = mode;
        assign bus.d     = d;
        assign valid_a[k] = bus.valid;
        assign done_a[k]  = bus.done;
        assign q_a[k]     = bus.q;
        tanh_act_block #(
            .DIM(DIM), .LANES(cfg_lanes(k)), .IN_W(IN_W), .OUT_W(OUT_W),
            .FRAC_W(OUT_W-2), .TBL_LAT(cfg_lat(k))
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    // Golden tanh in Q4.12 -> Q2.14: linear to 0.5, slope 5/16 to 2.0, slope 1/32 to 3.0, then 1.0.
    function automatic int gold_tanh(int x);
        int a, m;
        a = (x < 0) ? -x : x;
        if (a < 2048)       m = a;
        else if (a < 8192)  m = 2048 + ((a - 2048) * 5) / 16;
        else if (a < 12288) m = 3968 + (a - 8192) / 32;
        else                m = 4096;
        return (x < 0) ? -4 * m : 4 * m;
    endfunction

    function automatic int expect_elem(int x, logic md);
        int y, rr;
        y = gold_tanh(x);
        if (!md) return y;
        rr = 16384 - (y * y) / 16384;
        if (rr < 0) rr = 0;
        if (rr > 16384) rr = 16384;
        return rr;
    endfunction

    function automatic int d_elem(int i);
        logic signed [IN_W-1:0] v;
        v = d[i*IN_W +: IN_W];
        return int'(v);
    endfunction

    int   n_tests = 0;
    int   n_fail  = 0;
    int   t       = 0;
    int   run_len = 0;
    logic m_mode  = 1'b0;
    int   exp_q    [NCFG][DIM];
    int   pend_vis [NCFG][DIM];
    int   pend_iss [NCFG][DIM];
    int   pend_val [NCFG][DIM];
    bit   pv       [NCFG];

    function automatic void model_clear();
        for (int k = 0; k < NCFG; k++) begin
            pv[k] = 1'b0;
            for (int i = 0; i < DIM; i++) begin
                exp_q[k][i]    = 0;
                pend_vis[k][i] = -1;
                pend_iss[k][i] = 0;
                pend_val[k][i] = 0;
            end
        end
    endfunction

    // Model: group g of a run becomes visible at run cycle g+LAT+2, provided run stayed high
    // through cycle g+LAT; valid from run cycle NG+LAT+1 on while run holds.
    always @(negedge clk) begin : cmp
        int lanes, lat, ng, idx, bad;
        logic ev, ed;
        logic [DIM*OUT_W-1:0] eq;
        t++;
        if (!rst_n) begin
            model_clear();
            run_len = 0;
        end else begin
            run_len = run ? run_len + 1 : 0;
            if (run_len == 1) m_mode = mode;
        end
        for (int k = 0; k < NCFG; k++) begin
            lanes = cfg_lanes(k);
            lat   = cfg_lat(k);
            ng    = DIM / lanes;
            if (rst_n) begin
                for (int gi = 0; gi < ng; gi++) begin
                    if (pend_vis[k][gi] == t) begin
                        for (int l = 0; l < lanes; l++)
                            exp_q[k][gi*lanes+l] = pend_val[k][gi*lanes+l];
                        pend_vis[k][gi] = -1;
                    end
                end
                if (!run) begin
                    for (int gi = 0; gi < ng; gi++)
                        if (pend_vis[k][gi] >= 0 && t <= pend_iss[k][gi] + lat) pend_vis[k][gi] = -1;
                end
                if (run && run_len - 1 < ng) begin
                    idx = run_len - 1;
                    pend_iss[k][idx] = t;
                    pend_vis[k][idx] = t + lat + 2;
                    for (int l = 0; l < lanes; l++)
                        pend_val[k][idx*lanes+l] = expect_elem(d_elem(idx*lanes+l), m_mode);
                end
            end
            ev = rst_n && run && (run_len - 1 >= ng + lat + 1);
            ed = ev && !pv[k];
            pv[k] = ev;
            for (int i = 0; i < DIM; i++) eq[i*OUT_W +: OUT_W] = OUT_W'(exp_q[k][i]);

            n_tests += 3;
            if (valid_a[k] !== ev) begin
                n_fail++;
                $display("FAIL valid cfg%0d cycle %0d: got %b expected %b", k, t, valid_a[k], ev);
            end
            if (done_a[k] !== ed) begin
                n_fail++;
                $display("FAIL done cfg%0d cycle %0d: got %b expected %b", k, t, done_a[k], ed);
            end
            if (q_a[k] !== eq) begin
                n_fail++;
                bad = 0;
                for (int i = DIM - 1; i >= 0; i--)
                    if (q_a[k][i*OUT_W +: OUT_W] !== eq[i*OUT_W +: OUT_W]) bad = i;
                $display("FAIL q cfg%0d cycle %0d elem %0d: got %0d expected %0d", k, t, bad,
                         $signed(q_a[k][bad*OUT_W +: OUT_W]), $signed(eq[bad*OUT_W +: OUT_W]));
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(string name, int got, int expv);
        n_tests++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    function automatic int q0(int i);
        logic signed [OUT_W-1:0] v;
        v = q_a[0][i*OUT_W +: OUT_W];
        return int'(v);
    endfunction

    task automatic set_d_ramp(int stp);
        for (int i = 0; i < DIM; i++) d[i*IN_W +: IN_W] = IN_W'(i * stp);
    endtask

    task automatic set_d_all(int v);
        for (int i = 0; i < DIM; i++) d[i*IN_W +: IN_W] = IN_W'(v);
    endtask

    task automatic wait_valid(string name);
        int kc;
        kc = 0;
        while (valid_a[0] !== 1'b1 && kc < 40) begin
            step(1);
            kc++;
        end
        check(name, kc, 9);
        check({name, "_done"}, int'(done_a[0]), 1);
    endtask

    initial begin
        rst_n = 1'b0;
        run   = 1'b1;
        mode  = 1'b0;
        d     = '0;
        model_clear();

        // Reset held with run high, then released with run low.
        step(3);
        check("reset_valid", int'(valid_a[0]), 0);
        check("reset_q23", q0(23), 0);
        run = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(2);

        // FWD ramp d[i] = i*512.
        set_d_ramp(512);
        mode = 1'b0;
        run  = 1'b1;
        wait_valid("fwd_first_valid");
        step(1);
        check("fwd_done_one_cycle", int'(done_a[0]), 0);
        step(25);
        check("fwd_q0", q0(0), 0);
        check("fwd_q1", q0(1), 2048);
        check("fwd_q8", q0(8), 10752);
        check("fwd_q23", q0(23), 16320);
        run = 1'b0;
        step(1);

        // DERIV at zero input and at both table extremes.
        set_d_all(0);
        mode = 1'b1;
        run  = 1'b1;
        step(32);
        check("deriv_zero_q0", q0(0), 16384);
        check("deriv_zero_q17", q0(17), 16384);
        run = 1'b0;
        step(1);
        for (int i = 0; i < DIM; i++) d[i*IN_W +: IN_W] = (i % 2 == 0) ? 16'h7fff : 16'h8000;
        run = 1'b1;
        step(32);
        check("deriv_max_q0", q0(0), 0);
        check("deriv_min_q1", q0(1), 0);
        run = 1'b0;
        step(1);

        // Abort: preload 10752 everywhere, then a 5-cycle run at d=512.
        set_d_all(4096);
        mode = 1'b0;
        run  = 1'b1;
        step(32);
        run = 1'b0;
        step(1);
        set_d_all(512);
        run = 1'b1;
        step(5);
        run = 1'b0;
        step(8);
        check("abort_q0", q0(0), 2048);
        check("abort_q11", q0(11), 2048);
        check("abort_q12", q0(12), 10752);
        check("abort_q23", q0(23), 10752);

        // Mode toggles mid-run are ignored; back-to-back run after a one-cycle gap.
        set_d_ramp(512);
        mode = 1'b1;
        run  = 1'b1;
        step(2);
        mode = 1'b0;
        step(3);
        mode = 1'b1;
        step(2);
        mode = 1'b0;
        step(25);
        check("toggle_q1", q0(1), 16128);
        check("toggle_q8", q0(8), 9328);
        run = 1'b0;
        set_d_ramp(-512);
        step(1);
        run = 1'b1;
        wait_valid("run2_first_valid");
        step(25);
        check("run2_q8", q0(8), -10752);
        check("run2_q23", q0(23), -16320);

        // Reset in the middle of a run clears everything at once.
        run = 1'b0;
        step(1);
        set_d_ramp(300);
        run = 1'b1;
        step(6);
        rst_n = 1'b0;
        #1;
        check("midreset_valid", int'(valid_a[0]), 0);
        check("midreset_q23", q0(23), 0);
        step(1);
        run = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(2);

        // Mixed-sign DERIV run for all configurations.
        for (int i = 0; i < DIM; i++) d[i*IN_W +: IN_W] = IN_W'((i % 2 == 1) ? -i * 700 : i * 700);
        mode = 1'b1;
        run  = 1'b1;
        step(32);
        run = 1'b0;
        step(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
